// File: rtl/piso_shift_reg.sv
// Parallel-in serial-out shift register with frame valid/last status.
// Optional even-parity trailer bit when PISO_PARITY_EN is defined.
module piso_shift_reg #(
  parameter int WIDTH     = 16,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] din_i,
  output logic             dout_o,
  output logic             dout_valid_o,
  output logic             last_o
);

`ifdef PISO_PARITY_EN
  localparam int FRAME = WIDTH + 1;
`else
  localparam int FRAME = WIDTH;
`endif
  localparam int CW = $clog2(FRAME + 1);

  logic [FRAME-1:0] shreg_q, shreg_d;
  logic [FRAME-1:0] load_word;
  logic [CW-1:0]    cnt_q, cnt_d;

  // Parity sits after the last data bit in shift order, so its position depends on direction.
  always_comb begin
`ifdef PISO_PARITY_EN
    if (MSB_FIRST) load_word = {din_i, ^din_i};
    else           load_word = {^din_i, din_i};
`else
    load_word = din_i;
`endif
  end

  always_comb begin
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    if (load_i) begin
      shreg_d = load_word;
      cnt_d   = CW'(FRAME);
    end else if (cnt_q != '0) begin
      if (MSB_FIRST) shreg_d = {shreg_q[FRAME-2:0], 1'b0};
      else           shreg_d = {1'b0, shreg_q[FRAME-1:1]};
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      shreg_q <= '0;
      cnt_q   <= '0;
    end else begin
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
    end
  end

  assign dout_o       = MSB_FIRST ? shreg_q[FRAME-1] : shreg_q[0];
  assign dout_valid_o = (cnt_q != '0);
  assign last_o       = (cnt_q == CW'(1));

endmodule

// File: tb/tb_piso_shift_reg.sv
// Randomized self-checking bench for piso_shift_reg, MSB-first and LSB-first instances.
// Model holds each frame as a queue of expected serial bits (honours PISO_PARITY_EN).
module tb_piso_shift_reg;
  localparam int W = 16;

  typedef bit bq_t[$];

  logic clk = 1'b0;
  logic rst, load;
  logic [W-1:0] din_m, din_l;
  logic dout_m, valid_m, last_m;
  logic dout_l, valid_l, last_l;

  int n_cmp = 0;
  int n_mis = 0;
  bq_t q_m, q_l;

  always #5 clk = ~clk;

  piso_shift_reg #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_msb (
    .clk_i(clk), .rst_i(rst), .load_i(load), .din_i(din_m),
    .dout_o(dout_m), .dout_valid_o(valid_m), .last_o(last_m));

  piso_shift_reg #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_lsb (
    .clk_i(clk), .rst_i(rst), .load_i(load), .din_i(din_l),
    .dout_o(dout_l), .dout_valid_o(valid_l), .last_o(last_l));

  function automatic bq_t frame_of(input logic [W-1:0] d, input bit msb);
    bq_t f;
    for (int i = 0; i < W; i++) f.push_back(msb ? d[W-1-i] : d[i]);
`ifdef PISO_PARITY_EN
    f.push_back(^d);
`endif
    return f;
  endfunction

  // {dout, dout_valid, last}; idle dout is 0 because zeros have been shifted in.
  function automatic logic [2:0] exp_of(input bq_t q);
    if (q.size() == 0) return 3'b000;
    return {logic'(q[0]), 1'b1, logic'(q.size() == 1)};
  endfunction

  task automatic step(input logic r, input logic l, input logic [W-1:0] dm, input logic [W-1:0] dl);
    rst = r; load = l; din_m = dm; din_l = dl;
    @(posedge clk);
    if (r) begin
      q_m.delete(); q_l.delete();
    end else if (l) begin
      q_m = frame_of(dm, 1'b1);
      q_l = frame_of(dl, 1'b0);
    end else begin
      if (q_m.size() != 0) void'(q_m.pop_front());
      if (q_l.size() != 0) void'(q_l.pop_front());
    end
    #1;
  endtask

  task automatic test_reset();
    for (int c = 0; c < 2; c++) begin
      step(1'b1, 1'b1, 16'hFFFF, 16'hFFFF);
      n_cmp++;
      if ({dout_m, valid_m, last_m} !== 3'b000) begin
        n_mis++;
        $display("FAIL reset_msb cyc=%0d got=%b want=000", c, {dout_m, valid_m, last_m});
      end
      n_cmp++;
      if ({dout_l, valid_l, last_l} !== 3'b000) begin
        n_mis++;
        $display("FAIL reset_lsb cyc=%0d got=%b want=000", c, {dout_l, valid_l, last_l});
      end
    end
  endtask

  // Drive one load then idle for n cycles, checking every cycle.
  task automatic run_frame(input string nm, input logic [W-1:0] dm, input logic [W-1:0] dl, input int n);
    for (int c = 0; c <= n; c++) begin
      if (c == 0) step(1'b0, 1'b1, dm, dl);
      else        step(1'b0, 1'b0, $urandom, $urandom);
      n_cmp++;
      if ({dout_m, valid_m, last_m} !== exp_of(q_m)) begin
        n_mis++;
        $display("FAIL %s_msb cyc=%0d got=%b want=%b", nm, c, {dout_m, valid_m, last_m}, exp_of(q_m));
      end
      n_cmp++;
      if ({dout_l, valid_l, last_l} !== exp_of(q_l)) begin
        n_mis++;
        $display("FAIL %s_lsb cyc=%0d got=%b want=%b", nm, c, {dout_l, valid_l, last_l}, exp_of(q_l));
      end
    end
  endtask

  task automatic test_basic();
    run_frame("basic", 16'hA5C3, 16'hA5C3, W + 3);
  endtask

  task automatic test_lsb_first();
    run_frame("lsb1", 16'h0001, 16'h0001, W + 3);
  endtask

  task automatic test_parity_pattern();
    run_frame("par7", 16'h0007, 16'h0007, W + 3);
  endtask

  task automatic test_held_load();
    for (int c = 0; c < W + 6; c++) begin
      step(1'b0, c < 3, 16'h8001, 16'h8001);
      n_cmp++;
      if ({dout_m, valid_m, last_m} !== exp_of(q_m)) begin
        n_mis++;
        $display("FAIL held_msb cyc=%0d got=%b want=%b", c, {dout_m, valid_m, last_m}, exp_of(q_m));
      end
      n_cmp++;
      if ({dout_l, valid_l, last_l} !== exp_of(q_l)) begin
        n_mis++;
        $display("FAIL held_lsb cyc=%0d got=%b want=%b", c, {dout_l, valid_l, last_l}, exp_of(q_l));
      end
      if (c < 3) begin
        n_cmp++;
        if ({dout_m, valid_m, last_m} !== 3'b110) begin
          n_mis++;
          $display("FAIL held_hold cyc=%0d got=%b want=110", c, {dout_m, valid_m, last_m});
        end
      end
    end
  endtask

  // Abort with a new load after 5 shifts, then reload on last for a gapless next frame.
  task automatic test_back_to_back();
    int c;
    bit b2b_done;
    logic [W-1:0] nxt;
    c = 0;
    b2b_done = 1'b0;
    nxt = 16'h0;
    while (c < 3 * W + 10) begin
      if (c == 0)                      step(1'b0, 1'b1, 16'hFFFF, 16'hFFFF);
      else if (c == 6)                 step(1'b0, 1'b1, 16'h0000, 16'h0000);
      else if (c > 6 && !b2b_done && q_m.size() == 1) begin
        nxt = W'($urandom);
        step(1'b0, 1'b1, nxt, ~nxt);
        b2b_done = 1'b1;
      end else                         step(1'b0, 1'b0, 16'h0, 16'h0);
      n_cmp++;
      if ({dout_m, valid_m, last_m} !== exp_of(q_m)) begin
        n_mis++;
        $display("FAIL b2b_msb cyc=%0d got=%b want=%b", c, {dout_m, valid_m, last_m}, exp_of(q_m));
      end
      n_cmp++;
      if ({dout_l, valid_l, last_l} !== exp_of(q_l)) begin
        n_mis++;
        $display("FAIL b2b_lsb cyc=%0d got=%b want=%b", c, {dout_l, valid_l, last_l}, exp_of(q_l));
      end
      c++;
    end
  endtask

  task automatic test_random();
    logic r, l;
    for (int c = 0; c < 600; c++) begin
      r = ($urandom_range(0, 63) == 0);
      l = (q_m.size() == 1) ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 9) == 0);
      step(r, l, W'($urandom), W'($urandom));
      n_cmp++;
      if ({dout_m, valid_m, last_m} !== exp_of(q_m)) begin
        n_mis++;
        $display("FAIL rand_msb cyc=%0d got=%b want=%b", c, {dout_m, valid_m, last_m}, exp_of(q_m));
      end
      n_cmp++;
      if ({dout_l, valid_l, last_l} !== exp_of(q_l)) begin
        n_mis++;
        $display("FAIL rand_lsb cyc=%0d got=%b want=%b", c, {dout_l, valid_l, last_l}, exp_of(q_l));
      end
    end
  endtask

  initial begin
    rst = 1'b1; load = 1'b0; din_m = '0; din_l = '0;
    test_reset();
    test_basic();
    test_held_load();
    test_back_to_back();
    test_lsb_first();
    test_parity_pattern();
    test_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
